// File: rtl/data_sram_resp_pkg.sv
// Shared widths, default parameters and the response-entry type for the
// data SRAM with queued responses.
package data_sram_resp_pkg;

  localparam int DATA_W         = 32;
  localparam int BE_W           = 4;
  localparam int DEF_ADDR_W     = 12;
  localparam int DEF_RESP_DEPTH = 3;

  // One queued response: read data (0 for writes/errors) plus range error.
  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } resp_t;

endpackage : data_sram_resp_pkg

// File: rtl/data_sram_resp_if.sv
// Request/response handshake bundle between a requester (master) and the
// SRAM block (slave).
interface data_sram_resp_if;
  import data_sram_resp_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [BE_W-1:0]   req_we;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface : data_sram_resp_if

// File: rtl/data_sram_resp_fifo.sv
// Response FIFO: DEPTH entries, pointers wrap modulo DEPTH, popping an
// empty FIFO is ignored. The caller guarantees it never pushes when full.
module resp_fifo
  import data_sram_resp_pkg::*;
#(
  parameter  int DEPTH = DEF_RESP_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  resp_t            push_data,
  input  logic             pop,
  output resp_t            head,
  output logic [CNT_W-1:0] count
);

  resp_t            store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_ok = pop && (count != '0);
  assign head   = store[rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= bump(wr_ptr);
      if (pop_ok) rd_ptr <= bump(rd_ptr);
      if (push && !pop_ok)      count <= count + 1'b1;
      else if (!push && pop_ok) count <= count - 1'b1;
    end
  end

  // Entry storage; contents are only visible through a non-zero count.
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= push_data;
  end

endmodule : resp_fifo

// File: rtl/data_sram_resp.sv
// Word-organised data SRAM with byte enables. Each accepted request yields
// exactly one queued response two cycles later (fire at N, resp_valid at
// N+2); out-of-range addresses produce an error response and no write.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int RESP_DEPTH = DEF_RESP_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  data_sram_resp_if.slave    bus
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int WORDS = 1 << IDX_W;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  logic [DATA_W-1:0] mem [WORDS];
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              is_write;
  logic              fire;
  logic              inflight;
  logic              p_rd_ok;
  logic              p_err;
  logic [DATA_W-1:0] rd_q;
  logic [CNT_W-1:0]  fifo_count;
  resp_t             push_data;
  resp_t             head;
  logic              pop;

  assign idx      = bus.req_addr[ADDR_W-1:2];
  assign in_range = (bus.req_addr >> ADDR_W) == '0;
  assign is_write = bus.req_we != '0;
  assign fire     = bus.req_valid && bus.req_ready;

  // Admission depends only on registered occupancy (queued + in flight), so
  // there is no path from req_valid or resp_ready; reset forces it low.
  assign bus.req_ready = reset && ((int'(fifo_count) + int'(inflight)) < RESP_DEPTH);

  // One-cycle request pipeline: remembers what kind of response to push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight <= 1'b0;
      p_rd_ok  <= 1'b0;
      p_err    <= 1'b0;
    end else begin
      inflight <= fire;
      p_rd_ok  <= fire && in_range && !is_write;
      p_err    <= fire && !in_range;
    end
  end

  // Byte-enabled write and registered read of the word array.
  // NOTE: the array and its read register have no reset so the array infers
  // as RAM and keeps its contents across reset; rd_q is only used when
  // p_rd_ok marks it valid.
  always_ff @(posedge clk) begin
    if (fire && in_range) begin
      if (is_write) begin
        for (int b = 0; b < BE_W; b++) begin
          if (bus.req_we[b]) mem[idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
        end
      end else begin
        rd_q <= mem[idx];
      end
    end
  end

  // Assemble the response entry for the request that fired last cycle.
  // NOTE: every field is assigned on every path so no latch is inferred.
  always_comb begin
    push_data.rdata = p_rd_ok ? rd_q : '0;
    push_data.err   = p_err;
  end

  assign pop = bus.resp_valid && bus.resp_ready;

  resp_fifo #(.DEPTH(RESP_DEPTH)) u_resp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign bus.resp_valid = fifo_count != '0;
  assign bus.resp_rdata = bus.resp_valid ? head.rdata : '0;
  assign bus.resp_err   = bus.resp_valid && head.err;

endmodule : data_sram_resp

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 Parameter ADDR_W, default 12, meaning byte-address width actually backed; memory holds 2^(ADDR_W-2) 32-bit words.
REQ-002 Parameter RESP_DEPTH, default 3, meaning number of response FIFO entries (minimum 2).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset: asserted when 0, released synchronously to clk.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  request accepted this cycle when req_valid is also 1.
REQ-007 req_we  input  4  byte write enables; 4'b0000 means read.
REQ-008 req_addr  input  32  byte address; bits [1:0] are ignored.
REQ-009 req_wdata  input  32  write data, byte lane i is bits [8i+7:8i].
REQ-010 resp_valid  output  1  response present.
REQ-011 resp_ready  input  1  consumer takes the response this cycle.
REQ-012 resp_rdata  output  32  read data; 0 for writes and errors.
REQ-013 resp_err  output  1  request address was out of range.

Function
REQ-014 The block SHALL produce exactly one response per accepted request, in acceptance order.
REQ-015 The block SHALL accept on a cycle where req_valid and req_ready are both 1 ("fire").
REQ-016 req_ready SHALL be 1 iff (fifo_count + inflight) < RESP_DEPTH, computed from registered state only, with no combinational path from req_valid or resp_ready.
REQ-017 inflight SHALL be a 1-bit register set on fire and otherwise cleared.
REQ-018 On a fire with req_addr[31:ADDR_W] == 0 and req_we != 0, the block SHALL update the enabled bytes of word req_addr[ADDR_W-1:2] at that edge.
REQ-019 On a fire with req_addr[31:ADDR_W] == 0 and req_we == 0, the block SHALL read the addressed word with 1-cycle latency and push it into the FIFO with err=0 at the following edge.
REQ-020 Writes SHALL push {rdata=0, err=0} at the edge after fire.
REQ-021 An out-of-range fire SHALL leave memory unmodified and push {rdata=0, err=1}.
REQ-022 The earliest resp_valid SHALL be the second cycle after the fire cycle, i.e. fire at cycle N gives resp_valid at cycle N+2.
REQ-023 resp_valid SHALL equal (fifo_count != 0); resp_rdata and resp_err SHALL show the FIFO head and hold stable while resp_valid=1 and resp_ready=0.
REQ-024 A pop occurs when resp_valid and resp_ready are both 1; push and pop in the same cycle SHALL leave the count unchanged.
REQ-025 FIFO read and write pointers SHALL wrap modulo RESP_DEPTH.
REQ-026 The FIFO SHALL never overflow, which REQ-016 guarantees; popping an empty FIFO SHALL have no effect.
REQ-027 A read accepted the cycle after a write to the same word SHALL return the newly written data.
REQ-028 With RESP_DEPTH >= 3 and resp_ready held at 1, the block SHALL sustain one fire per cycle.
REQ-029 With RESP_DEPTH = 2 and resp_ready held at 1, the block SHALL sustain two fires every three cycles.

Reset
REQ-030 While reset=0, the block SHALL drive req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, inflight=0, fifo_count=0, and both pointers to 0.
REQ-031 Reset asserted mid-operation SHALL discard in-flight and queued responses without emitting them.
REQ-032 Memory contents SHALL NOT be reset and SHALL retain prior writes across reset.
REQ-033 req_ready SHALL become 1 in the first cycle after reset release.

Structure
REQ-034 The shared package SHALL hold the data width (32), byte-enable width (4), the default ADDR_W, the default RESP_DEPTH, and the response-entry type {rdata[31:0], err}.
REQ-035 One sub-module, resp_fifo, SHALL implement the parameterised synchronous FIFO using the same clk and reset.
REQ-036 The memory SHALL be an inferred word array with per-byte write enables.

Verification
REQ-037 Write-then-read: write 0xDEADBEEF to 0x10 with we=4'hF, then read 0x10 next cycle -> write response {0,0}, then read response rdata=0xDEADBEEF, err=0.
REQ-038 Byte lanes: 0x10 holds 0xDEADBEEF; write 0x000000AA with we=4'b0001; read 0x10 -> rdata=0xDEADBEAA.
REQ-039 Out of range: read 0x00001000 with ADDR_W=12 -> rdata=0, err=1; a write to the same address followed by a read of 0x0 shows word 0 unchanged.
REQ-040 Backpressure: resp_ready=0 while issuing 3 reads -> after 3 fires req_ready=0 and the head holds stable; resp_ready=1 drains the responses in order, then req_ready returns to 1.
REQ-041 Throughput: RESP_DEPTH=3, req_valid and resp_ready held at 1 for 20 cycles -> 20 fires and 20 in-order responses; RESP_DEPTH=2 -> 2 fires per 3 cycles.
REQ-042 Mid-operation reset: reset=0 with 2 responses queued and 1 in flight -> resp_valid=0 immediately and no stale response after release; a read of a previously written word returns the pre-reset value.
